// File: rtl/block_emitter.sv
// Streams "begin"/"end" keywords one character per beat, each followed by a space,
// and tracks whether the accepted command stream is balanced.
module block_emitter #(
  parameter int unsigned DEPTH_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd,
  input  logic       cmd_upper,
  output logic       cmd_ready,
  output logic [7:0] out_char,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       result
);

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CHAR_W = 8;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};
  localparam logic [CHAR_W-1:0]  SPACE     = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    WORD,
    SEP
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic               kind, kind_n;
  logic               upper, upper_n;
  logic [DEPTH_W-1:0] depth, depth_n;
  logic               broken, broken_n;
  logic               last;
  logic [CHAR_W-1:0]  char_n;

  // Letter ROM; uppercase is the lowercase code with bit 5 cleared.
  function automatic logic [CHAR_W-1:0] letter(input logic is_end, input logic up,
                                               input logic [IDX_W-1:0] i);
    logic [CHAR_W-1:0] c;
    c = 8'h00;
    if (is_end) begin
      case (i)
        3'd0:    c = 8'h65;
        3'd1:    c = 8'h6E;
        3'd2:    c = 8'h64;
        default: c = 8'h00;
      endcase
    end else begin
      case (i)
        3'd0:    c = 8'h62;
        3'd1:    c = 8'h65;
        3'd2:    c = 8'h67;
        3'd3:    c = 8'h69;
        3'd4:    c = 8'h6E;
        default: c = 8'h00;
      endcase
    end
    if (up) c = c & 8'hDF;
    return c;
  endfunction

  // Next-state, depth bookkeeping and next output values.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    kind_n   = kind;
    upper_n  = upper;
    depth_n  = depth;
    broken_n = broken;
    char_n   = 8'h00;
    last     = (idx == (kind ? 3'd2 : 3'd4));

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_n = WORD;
          idx_n   = '0;
          kind_n  = cmd;
          upper_n = cmd_upper;
          if (!cmd) begin
            if (depth == DEPTH_MAX) broken_n = 1'b1;
            else                    depth_n  = depth + DEPTH_W'(1);
          end else begin
            if (depth == '0) broken_n = 1'b1;
            else             depth_n  = depth - DEPTH_W'(1);
          end
        end
      end
      WORD: begin
        if (out_ready) begin
          if (last) state_n = SEP;
          else      idx_n   = idx + IDX_W'(1);
        end
      end
      SEP: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      WORD:    char_n = letter(kind_n, upper_n, idx_n);
      SEP:     char_n = SPACE;
      default: char_n = 8'h00;
    endcase
  end

  // State and registered outputs; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      kind      <= 1'b0;
      upper     <= 1'b0;
      depth     <= '0;
      broken    <= 1'b0;
      cmd_ready <= 1'b1;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      result    <= 1'b1;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      kind      <= kind_n;
      upper     <= upper_n;
      depth     <= depth_n;
      broken    <= broken_n;
      cmd_ready <= (state_n == IDLE);
      out_valid <= (state_n != IDLE);
      out_char  <= char_n;
      result    <= !broken_n && (depth_n == '0);
    end
  end

endmodule

// File: tb/tb_block_emitter.sv
// Checks two block_emitter instances (default depth and DEPTH_W=2) against a
// character-queue reference model under directed and random stimulus.
module tb_block_emitter;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd;
  logic       cmd_upper;
  logic       out_ready;

  logic       cmd_ready_a, out_valid_a, result_a;
  logic [7:0] out_char_a;
  logic       cmd_ready_b, out_valid_b, result_b;
  logic [7:0] out_char_b;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  int         d8, d2;
  bit         b8, b2;

  block_emitter u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_upper (cmd_upper),
    .cmd_ready (cmd_ready_a),
    .out_char  (out_char_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .result    (result_a)
  );

  block_emitter #(.DEPTH_W(2)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_upper (cmd_upper),
    .cmd_ready (cmd_ready_b),
    .out_char  (out_char_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .result    (result_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the edge's sampled inputs to the model.
  task automatic model_edge();
    string      s;
    logic [7:0] ch;
    if (!reset) begin
      exp_q.delete();
      d8 = 0; d2 = 0; b8 = 0; b2 = 0;
    end else if (exp_q.size() == 0) begin
      if (cmd_valid) begin
        s = cmd ? "end" : "begin";
        for (int i = 0; i < s.len(); i++) begin
          ch = s[i];
          if (cmd_upper) ch = ch - 8'h20;
          exp_q.push_back(ch);
        end
        exp_q.push_back(8'h20);
        if (!cmd) begin
          if (d8 == 255) b8 = 1; else d8++;
          if (d2 == 3)   b2 = 1; else d2++;
        end else begin
          if (d8 == 0) b8 = 1; else d8--;
          if (d2 == 0) b2 = 1; else d2--;
        end
      end
    end else if (out_ready) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic check_all();
    logic       ev;
    logic [7:0] ec;
    ev = (exp_q.size() != 0);
    ec = ev ? exp_q[0] : 8'h00;
    chk("a_out_valid", 8'(out_valid_a), 8'(ev));
    chk("a_out_char",  out_char_a,      ec);
    chk("a_cmd_ready", 8'(cmd_ready_a), 8'(!ev));
    chk("a_result",    8'(result_a),    8'(!b8 && d8 == 0));
    chk("b_out_valid", 8'(out_valid_b), 8'(ev));
    chk("b_out_char",  out_char_b,      ec);
    chk("b_cmd_ready", 8'(cmd_ready_b), 8'(!ev));
    chk("b_result",    8'(result_b),    8'(!b2 && d2 == 0));
  endtask

  task automatic cycle(input logic rst, input logic cv, input logic c,
                       input logic cu, input logic ordy);
    reset = rst; cmd_valid = cv; cmd = c; cmd_upper = cu; out_ready = ordy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Accept one command, then drain with garbage on cmd/cmd_upper.
  task automatic run_cmd(input logic c, input logic cu);
    cycle(1'b1, 1'b1, c, cu, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, ~c, ~cu, 1'b1);
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd = 1'b0; cmd_upper = 1'b0; out_ready = 1'b0;
    d8 = 0; d2 = 0; b8 = 0; b2 = 0;

    // Reset state
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_result", 8'(result_a), 8'h01);

    // lowercase begin then uppercase END
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("dir_first_b", out_char_a, 8'h62);
    chk("dir_begin_result", 8'(result_a), 8'h00);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("dir_first_E", out_char_a, 8'h45);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("dir_end_result", 8'(result_a), 8'h01);

    // Sticky broken flag
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_cmd(1'b1, 1'b0);
    chk("dir_underflow", 8'(result_a), 8'h00);
    run_cmd(1'b0, 1'b0);
    run_cmd(1'b1, 1'b0);
    chk("dir_sticky", 8'(result_a), 8'h00);

    // Back-pressure on 'g'
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("dir_stall_g", out_char_a, 8'h67);
    end
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("dir_abort_valid", 8'(out_valid_a), 8'h00);
    chk("dir_abort_result", 8'(result_a), 8'h01);
    run_cmd(1'b1, 1'b1);

    // Depth saturation on the narrow instance
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) run_cmd(1'b0, 1'b0);
    chk("dir_sat_result", 8'(result_b), 8'h00);
    for (int i = 0; i < 3; i++) run_cmd(1'b1, 1'b1);
    chk("dir_sat_broken", 8'(result_b), 8'h00);
    chk("dir_wide_balanced", 8'(result_a), 8'h00);
    run_cmd(1'b1, 1'b0);
    chk("dir_wide_back", 8'(result_a), 8'h01);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 63) != 0), 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
